// File: rtl/ysyx_24090018_rf_wb_arb_pkg.sv
// ysyx_24090018_rf_wb_arb_pkg: requester IDs and default widths shared by the writeback arbiter
package ysyx_24090018_rf_wb_arb_pkg;
    localparam int DEF_REG_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 32;
    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_t;
endpackage

// File: rtl/ysyx_24090018_rf_wb_arb_if.sv
// ysyx_24090018_rf_wb_arb_if: decode, EXU/LSU writeback and register-file write bundle
interface ysyx_24090018_rf_wb_arb_if
    import ysyx_24090018_rf_wb_arb_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic issue_i;
    logic [REG_ADDR_WIDTH-1:0] issue_rd_i;
    logic [REG_ADDR_WIDTH-1:0] rs1_i;
    logic [REG_ADDR_WIDTH-1:0] rs2_i;
    logic hazard_o;
    logic exu_valid_i;
    logic exu_ready_o;
    logic [REG_ADDR_WIDTH-1:0] exu_waddr_i;
    logic [DATA_WIDTH-1:0] exu_wdata_i;
    logic lsu_valid_i;
    logic lsu_ready_o;
    logic [REG_ADDR_WIDTH-1:0] lsu_waddr_i;
    logic [DATA_WIDTH-1:0] lsu_wdata_i;
    logic rf_wen_o;
    logic [REG_ADDR_WIDTH-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;

    modport master (
        output issue_i, issue_rd_i, rs1_i, rs2_i,
        output exu_valid_i, exu_waddr_i, exu_wdata_i,
        output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        input hazard_o, exu_ready_o, lsu_ready_o,
        input rf_wen_o, rf_waddr_o, rf_wdata_o
    );

    modport slave (
        input issue_i, issue_rd_i, rs1_i, rs2_i,
        input exu_valid_i, exu_waddr_i, exu_wdata_i,
        input lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
        output hazard_o, exu_ready_o, lsu_ready_o,
        output rf_wen_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/ysyx_24090018_rr_arb2.sv
// ysyx_24090018_rr_arb2: two-way round-robin arbiter; a tie goes to the requester not granted last
module ysyx_24090018_rr_arb2
    import ysyx_24090018_rf_wb_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    req_id_t last_grant;

    // grant a lone requester immediately; on a tie favour the one not granted last
    always_comb begin
        grant = (valid == 2'b11) ? ((last_grant == REQ_LSU) ? 2'b01 : 2'b10) : valid;
    end

    // remember the winner of every transfer; reset makes EXU win the first tie
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= REQ_LSU;
        else if (|grant)
            last_grant <= grant[REQ_LSU] ? REQ_LSU : REQ_EXU;
    end
endmodule

// File: rtl/ysyx_24090018_rf_wb_arb.sv
// ysyx_24090018_rf_wb_arb: EXU/LSU writeback arbiter with register scoreboard and registered RF write port
module ysyx_24090018_rf_wb_arb
    import ysyx_24090018_rf_wb_arb_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic clk,
    input logic rst,
    ysyx_24090018_rf_wb_arb_if.slave bus
);
    localparam int NREG = 1 << REG_ADDR_WIDTH;

    logic [1:0] grant;
    logic xfer;
    logic [REG_ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    ysyx_24090018_rr_arb2 u_arb (
        .clk(clk),
        .rst(rst),
        .valid({bus.lsu_valid_i, bus.exu_valid_i}),
        .grant(grant)
    );

    // ready depends only on valids and arbitration state, held low through reset
    assign bus.exu_ready_o = grant[REQ_EXU] & ~rst;
    assign bus.lsu_ready_o = grant[REQ_LSU] & ~rst;
    assign xfer = bus.exu_ready_o | bus.lsu_ready_o;
    assign w_addr = grant[REQ_LSU] ? bus.lsu_waddr_i : bus.exu_waddr_i;
    assign w_data = grant[REQ_LSU] ? bus.lsu_wdata_i : bus.exu_wdata_i;

    // stall on any pending write to a source or to the new destination; no bypass
    assign bus.hazard_o = busy_q[bus.rs1_i] | busy_q[bus.rs2_i] | (bus.issue_i & busy_q[bus.issue_rd_i]);

    // next scoreboard: writeback clears, issue sets and wins a same-register collision; x0 never busy
    always_comb begin
        busy_d = busy_q;
        if (xfer && w_addr != '0) busy_d[w_addr] = 1'b0;
        if (bus.issue_i && bus.issue_rd_i != '0) busy_d[bus.issue_rd_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // scoreboard and RF write port update together so hazard drops in the rf_wen cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            bus.rf_wen_o <= 1'b0;
            bus.rf_waddr_o <= '0;
            bus.rf_wdata_o <= '0;
        end else begin
            busy_q <= busy_d;
            bus.rf_wen_o <= xfer && w_addr != '0;
            if (xfer) begin
                bus.rf_waddr_o <= w_addr;
                bus.rf_wdata_o <= w_data;
            end
        end
    end
endmodule

// File: doc/ysyx_24090018_rf_wb_arb.md
YSYX_24090018_RF_WB_ARB -- requirements
Module: ysyx_24090018_rf_wb_arb

Interface
REQ-001 Parameters SHALL be: REG_ADDR_WIDTH, default 4, register address width; DATA_WIDTH, default 32, register data width.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 issue_i  in  1  decode issues an instruction that writes issue_rd_i.
REQ-005 issue_rd_i  in  REG_ADDR_WIDTH  destination register of the issued instruction.
REQ-006 rs1_i, rs2_i  in  REG_ADDR_WIDTH each  source registers of the instruction in decode.
REQ-007 hazard_o  out  1  decode SHALL stall: rs1_i, rs2_i or issue_rd_i has a pending write.
REQ-008 exu_valid_i / exu_ready_o  in / out  1 / 1  EXU writeback handshake.
REQ-009 exu_waddr_i, exu_wdata_i  in  REG_ADDR_WIDTH, DATA_WIDTH  EXU writeback address and data.
REQ-010 lsu_valid_i / lsu_ready_o, lsu_waddr_i, lsu_wdata_i: same as REQ-008/009, for LSU load writeback.
REQ-011 rf_wen_o, rf_waddr_o, rf_wdata_o  out  1, REG_ADDR_WIDTH, DATA_WIDTH  register-file write port, all registered.

Function
REQ-012 Transfer SHALL occur on a cycle where valid and ready are both high; ready SHALL be combinational from valids and arbitration state only, never from data.
REQ-013 At most one requester SHALL be granted per cycle; a lone valid requester SHALL be granted in the same cycle.
REQ-014 Both valid: grant SHALL go to the requester not granted most recently (round-robin, 1-bit last_grant updated only on a transfer).
REQ-015 A valid requester SHALL hold its address and data stable until accepted; the arbiter SHALL NOT drop a valid request, so the worst-case wait is 1 cycle.
REQ-016 An accepted write SHALL appear on rf_wen_o/rf_waddr_o/rf_wdata_o exactly 1 cycle after transfer, with rf_wen_o high for exactly 1 cycle.
REQ-017 A transfer with waddr 0 SHALL be accepted, with rf_wen_o held 0 the following cycle.
REQ-018 The scoreboard SHALL hold one busy bit per register (2**REG_ADDR_WIDTH bits); bit 0 SHALL be constantly 0.
REQ-019 issue_i with issue_rd_i!=0 SHALL set busy[issue_rd_i] at the next edge.
REQ-020 A transfer to waddr!=0 SHALL clear busy[waddr] at the next edge.
REQ-021 Set and clear of the same register in the same cycle: set SHALL win.
REQ-022 hazard_o SHALL equal busy[rs1_i] | busy[rs2_i] | (issue_i & busy[issue_rd_i]), from registered busy bits only; there is no same-cycle bypass.
REQ-023 hazard_o SHALL deassert in the cycle rf_wen_o is asserted for the last pending register, so RF read-after-write is safe next cycle.
REQ-024 issue_i while hazard_o is high is an upstream protocol violation; the block SHALL still apply REQ-019.

Reset
REQ-025 While rst is high at a posedge: all busy bits SHALL be 0, last_grant = LSU (EXU wins the first tie), rf_wen_o = 0, rf_waddr_o = 0, rf_wdata_o = 0.
REQ-026 exu_ready_o and lsu_ready_o SHALL be 0 while rst is high.
REQ-027 Reset mid-operation SHALL discard any registered in-flight write: no rf_wen_o pulse in the cycle after reset.

Structure
REQ-028 The shared package SHALL hold the requester-ID encoding (EXU=0, LSU=1) and the default widths.
REQ-029 Round-robin arbitration SHALL be one sub-module, ysyx_24090018_rr_arb2 (valid[1:0] in, grant[1:0] out, last_grant state); the scoreboard SHALL be inline.

Verification
REQ-030 After reset, exu_valid_i=1 and lsu_valid_i=1 held: grants SHALL alternate EXU, LSU, EXU; rf_wen_o SHALL pulse each cycle, starting 1 cycle after the first grant.
REQ-031 issue_i with rd=5; next cycle rs1_i=5: hazard_o=1. EXU writes x5=0xDEADBEEF: rf_wen_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF next cycle, with hazard_o=0 in that cycle.
REQ-032 lsu_valid_i with waddr=0, wdata=0x1234: lsu_ready_o=1; rf_wen_o SHALL stay 0 next cycle; busy[0] SHALL stay 0.
REQ-033 Same cycle: issue_i rd=7 and EXU transfer to x7 (earlier x7 pending): busy[7] SHALL be 1 afterwards and hazard_o=1 for rs2_i=7.
REQ-034 With busy[3]=1, rd=3 in flight and an EXU request pending, assert rst for 1 cycle: no rf_wen_o pulse follows, all busy bits are 0, and hazard_o=0 for rs1_i=3.
